alu_share_arbiter: RTL

- Shares the single-cycle 32-bit ALU between two requesters: port 0 is the main datapath, port 1 is the auxiliary/multicycle unit.
- Arbitrates round-robin and drives the ALU operand/control inputs combinationally from the granted port.
- Captures the ALU result in a one-entry response register and returns it to the requester that issued it.
- Post-processes SLT so the response carries a true signed-compare bit, not the raw difference.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_share_arbiter_if.sv | 25 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/alu_share_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, datapath width, response slot states
// and the signed-compare fixup applied to SLT results.
package alu_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 2;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SLLV = 3'b110;
  localparam logic [2:0] ALU_SRAV = 3'b111;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  // The ALU hands back the raw difference for SLT; correct its sign for overflow.
  function automatic logic [DATA_W-1:0] slt_fix(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] diff);
    logic ovf;
    ovf = (a[DATA_W-1] ^ b[DATA_W-1]) & (a[DATA_W-1] ^ diff[DATA_W-1]);
    return {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ ovf};
  endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_ready;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_srca;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_srcb;
  logic [NUM_PORTS-1:0][2:0]        req_ctrl;
  logic [NUM_PORTS-1:0][4:0]        req_shamt;
  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [NUM_PORTS-1:0]             rsp_ready;
  logic [DATA_W-1:0]                rsp_result;
  logic                             rsp_zero;

  modport master (
    output req_valid, req_srca, req_srcb, req_ctrl, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_srca, req_srcb, req_ctrl, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer names the port that wins a tie and
// moves to the loser on every accept.
module rr_arbiter2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= RR_INIT;
    else if (accept) ptr_q <= ~grant[1];
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two requesters with a one-entry
// response slot that supports one op per cycle when responses drain.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [2:0]        alu_ctrl,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);
  slot_state_t       state_q, state_d;
  logic              owner_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [1:0]        grant;
  logic              gsel, consume, slot_free, accept;
  logic [DATA_W-1:0] result_fix;
  logic              unused_alu_zero;

  // Zero is recomputed from the fixed-up result, so the ALU flag is not needed.
  assign unused_alu_zero = alu_zero;

  assign consume   = (state_q == FULL) & bus.rsp_ready[owner_q];
  assign slot_free = (state_q == EMPTY) | consume;

  rr_arbiter2 #(.RR_INIT(1'(RR_INIT))) u_rr (
    .clk    (clk),
    .rst_n  (reset_n),
    .req    (bus.req_valid),
    .en     (slot_free),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);

  // Port 1 is selected only on its grant; otherwise port 0 passes through.
  assign gsel      = grant[1];
  assign alu_srca  = bus.req_srca[gsel];
  assign alu_srcb  = bus.req_srcb[gsel];
  assign alu_ctrl  = bus.req_ctrl[gsel];
  assign alu_shamt = bus.req_shamt[gsel];

  assign result_fix = (alu_ctrl == ALU_SLT) ? slt_fix(alu_srca, alu_srcb, alu_result)
                                            : alu_result;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
    assign bus.rsp_valid[i] = (state_q == FULL) & (owner_q == 1'(i));
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;

  always_comb begin
    state_d = state_q;
    if (accept)       state_d = FULL;
    else if (consume) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= gsel;
        result_q <= result_fix;
        zero_q   <= (result_fix == '0);
      end
    end
  end
endmodule
